// File: rtl/dev_bridge_intc.sv
// CPU-side device bus bridge: address decode, read-data mux and a small interrupt
// controller (synchroniser, level/edge pending latch, mask) feeding the CP0 lines.
module dev_bridge_intc #(
  parameter int unsigned NDEV = 4,
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pr_addr,
  input  logic [31:0]          pr_wd,
  input  logic                 pr_we,
  output logic [31:0]          pr_rd,
  output logic [5:0]           hw_int,
  output logic [7:0]           dev_addr,
  output logic [31:0]          dev_in,
  output logic [NDEV-1:0]      dev_we,
  input  logic [32*NDEV-1:0]   dev_out,
  input  logic [NDEV-1:0]      dev_irq
);

  logic            hit;
  logic [3:0]      slot;
  logic            ctl_sel;
  logic            wr_ctl;
  logic [1:0]      reg_sel;
  logic [NDEV-1:0] wd_n;

  logic [NDEV-1:0] irq_q, irq_q2;
  logic [NDEV-1:0] pend_q, pend_d;
  logic [NDEV-1:0] mask_q, mask_d;
  logic [NDEV-1:0] edge_q, edge_d;
  logic [NDEV-1:0] clr, rise;
  logic [5:0]      hw_int_d;

  assign hit      = (pr_addr[31:8] == BASE[31:8]);
  assign slot     = pr_addr[7:4];
  assign ctl_sel  = hit && (slot == 4'hF);
  assign wr_ctl   = pr_we && ctl_sel;
  // Byte lane bits [1:0] are ignored, so registers are selected by word.
  assign reg_sel  = pr_addr[3:2];
  assign wd_n     = pr_wd[NDEV-1:0];
  assign dev_addr = {4'b0, pr_addr[3:0]};
  assign dev_in   = pr_wd;

  always_comb begin
    dev_we = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (pr_we && hit && (int'(slot) == i)) dev_we[i] = 1'b1;
    end
  end

  always_comb begin
    pr_rd = '0;
    if (ctl_sel) begin
      case (reg_sel)
        2'd0:    pr_rd = 32'(pend_q);
        2'd1:    pr_rd = 32'(mask_q);
        2'd2:    pr_rd = 32'(edge_q);
        default: pr_rd = 32'(irq_q);
      endcase
    end else if (hit) begin
      for (int i = 0; i < int'(NDEV); i++) begin
        if (int'(slot) == i) pr_rd = dev_out[32*i +: 32];
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    clr    = '0;
    if (wr_ctl) begin
      case (reg_sel)
        2'd0:    clr    = wd_n;
        2'd1:    mask_d = wd_n;
        2'd2:    edge_d = wd_n;
        default: ;
      endcase
    end
    rise = irq_q & ~irq_q2;
    // Edge bits latch rises (a rise beats a same-cycle clear); level bits follow irq_q.
    pend_d   = (edge_q & ((pend_q & ~clr) | rise)) | (~edge_q & irq_q);
    hw_int_d = 6'(pend_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q  <= '0;
      irq_q2 <= '0;
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      hw_int <= '0;
    end else begin
      irq_q  <= dev_irq;
      irq_q2 <= irq_q;
      pend_q <= pend_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      hw_int <= hw_int_d;
    end
  end

endmodule

// File: tb/tb_dev_bridge_intc.sv
// Bench for dev_bridge_intc: directed scenarios plus a randomized run checked
// against a cycle-stepped behavioural model of the bridge and controller.
module tb_dev_bridge_intc;
  localparam int unsigned NDEV = 4;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         pr_addr, pr_wd, pr_rd, dev_in;
  logic                pr_we;
  logic [5:0]          hw_int;
  logic [7:0]          dev_addr;
  logic [NDEV-1:0]     dev_we, dev_irq;
  logic [32*NDEV-1:0]  dev_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NDEV-1:0] m_irq_q, m_irq_q2, m_pend, m_mask, m_edge;
  logic [5:0]      m_hw;

  dev_bridge_intc #(.NDEV(NDEV), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we),
    .pr_rd(pr_rd), .hw_int(hw_int), .dev_addr(dev_addr), .dev_in(dev_in),
    .dev_we(dev_we), .dev_out(dev_out), .dev_irq(dev_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    int s;
    s = int'(a[7:4]);
    if ((a >> 8) != (BASE >> 8)) return 32'h0;
    if (s < int'(NDEV)) return dev_out[32*s +: 32];
    if (s != 15) return 32'h0;
    case (int'(a[3:2]))
      0:       return 32'(m_pend);
      1:       return 32'(m_mask);
      2:       return 32'(m_edge);
      default: return 32'(m_irq_q);
    endcase
  endfunction

  function automatic logic [NDEV-1:0] exp_we();
    logic [NDEV-1:0] r;
    int s;
    r = '0;
    s = int'(pr_addr[7:4]);
    if (pr_we && ((pr_addr >> 8) == (BASE >> 8)) && s < int'(NDEV)) r[s] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_irq_q = '0; m_irq_q2 = '0; m_pend = '0; m_mask = '0; m_edge = '0; m_hw = '0;
  endtask

  // Advance one clock: model next state from present inputs, then step both.
  task automatic tick();
    logic [NDEV-1:0] clr, np, nm, ne, irq_in;
    logic [5:0] nh;
    int s, r;
    s = int'(pr_addr[7:4]);
    r = int'(pr_addr[3:2]);
    clr = '0; nm = m_mask; ne = m_edge; irq_in = dev_irq;
    if (pr_we && ((pr_addr >> 8) == (BASE >> 8)) && s == 15) begin
      if (r == 0) clr = pr_wd[NDEV-1:0];
      if (r == 1) nm = pr_wd[NDEV-1:0];
      if (r == 2) ne = pr_wd[NDEV-1:0];
    end
    for (int b = 0; b < int'(NDEV); b++) begin
      if (!m_edge[b])                     np[b] = m_irq_q[b];
      else if (m_irq_q[b] && !m_irq_q2[b]) np[b] = 1'b1;
      else if (clr[b])                    np[b] = 1'b0;
      else                                np[b] = m_pend[b];
    end
    nh = '0;
    for (int b = 0; b < int'(NDEV); b++) nh[b] = m_pend[b] & m_mask[b];
    @(posedge clk);
    m_irq_q2 = m_irq_q; m_irq_q = irq_in; m_pend = np; m_mask = nm; m_edge = ne; m_hw = nh;
    #1;
    pr_we = 1'b0;
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d);
    pr_addr = a; pr_wd = d; pr_we = 1'b1;
    tick();
  endtask

  task automatic set_rd(logic [31:0] a);
    pr_addr = a; pr_we = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pr_addr = '0; pr_wd = '0; pr_we = 1'b0; dev_irq = '0; dev_out = '0;
    model_reset();
    #12;
    n_tests++; if (hw_int !== 6'h0) begin n_fail++; $display("FAIL reset_hw_int: got %h want 00", hw_int); end
    set_rd(32'h7FF0);
    n_tests++; if (pr_rd !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pr_rd); end
    set_rd(32'h7FF4);
    n_tests++; if (pr_rd !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", pr_rd); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    pr_addr = 32'h7F14; pr_wd = 32'h55; pr_we = 1'b1; #1;
    n_tests++; if (dev_we !== 4'b0010) begin n_fail++; $display("FAIL decode_we: got %b want 0010", dev_we); end
    n_tests++; if (dev_addr !== 8'h04) begin n_fail++; $display("FAIL decode_addr: got %h want 04", dev_addr); end
    n_tests++; if (dev_in !== 32'h55) begin n_fail++; $display("FAIL decode_in: got %h want 55", dev_in); end
    tick();
    pr_addr = 32'h7F54; pr_wd = 32'h55; pr_we = 1'b1; #1;
    n_tests++; if (dev_we !== 4'b0000) begin n_fail++; $display("FAIL decode_unmapped: got %b want 0000", dev_we); end
    tick();
    pr_addr = 32'h8000; pr_wd = 32'h55; pr_we = 1'b1; #1;
    n_tests++; if (dev_we !== 4'b0000) begin n_fail++; $display("FAIL decode_outside: got %b want 0000", dev_we); end
    tick();
    set_rd(32'h7FF4);
    n_tests++; if (pr_rd !== 32'h0) begin n_fail++; $display("FAIL decode_no_change: mask %h want 0", pr_rd); end
  endtask

  task automatic test_read_mux();
    for (int i = 0; i < int'(NDEV); i++) dev_out[32*i +: 32] = $urandom;
    dev_out[64 +: 32] = 32'hDEADBEEF;
    set_rd(32'h7F20);
    n_tests++; if (pr_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mux_dev2: got %h want deadbeef", pr_rd); end
    set_rd(32'h7F23);
    n_tests++; if (pr_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mux_lowbits: got %h want deadbeef", pr_rd); end
    set_rd(32'h7F60);
    n_tests++; if (pr_rd !== 32'h0) begin n_fail++; $display("FAIL mux_unmapped: got %h want 0", pr_rd); end
    set_rd(32'h8020);
    n_tests++; if (pr_rd !== 32'h0) begin n_fail++; $display("FAIL mux_outside: got %h want 0", pr_rd); end
  endtask

  task automatic test_level();
    bus_write(32'h7FF8, 32'h0);
    bus_write(32'h7FF4, 32'h1);
    dev_irq = 4'b0001;
    tick(); tick();
    n_tests++; if (hw_int !== 6'h00) begin n_fail++; $display("FAIL level_early: got %h want 00", hw_int); end
    tick();
    n_tests++; if (hw_int !== 6'h01) begin n_fail++; $display("FAIL level_rise: got %h want 01", hw_int); end
    bus_write(32'h7FF0, 32'h1);
    set_rd(32'h7FF0);
    n_tests++; if (pr_rd !== 32'h1) begin n_fail++; $display("FAIL level_w1c: pending %h want 1", pr_rd); end
    dev_irq = 4'b0000;
    tick(); tick();
    n_tests++; if (hw_int !== 6'h01) begin n_fail++; $display("FAIL level_hold: got %h want 01", hw_int); end
    tick();
    n_tests++; if (hw_int !== 6'h00) begin n_fail++; $display("FAIL level_fall: got %h want 00", hw_int); end
  endtask

  task automatic test_edge();
    bus_write(32'h7FF8, 32'h2);
    bus_write(32'h7FF4, 32'h2);
    dev_irq = 4'b0010; tick();
    dev_irq = 4'b0000; tick(); tick(); tick(); tick();
    set_rd(32'h7FF0);
    n_tests++; if (pr_rd !== 32'h2) begin n_fail++; $display("FAIL edge_pending: got %h want 2", pr_rd); end
    n_tests++; if (hw_int !== 6'b000010) begin n_fail++; $display("FAIL edge_hw_int: got %h want 02", hw_int); end
    bus_write(32'h7FF0, 32'h2);
    set_rd(32'h7FF0);
    n_tests++; if (pr_rd !== 32'h0) begin n_fail++; $display("FAIL edge_clear: got %h want 0", pr_rd); end
    tick();
    n_tests++; if (hw_int !== 6'h00) begin n_fail++; $display("FAIL edge_clear_hw: got %h want 00", hw_int); end
    dev_irq = 4'b0010; tick();
    dev_irq = 4'b0000;
    bus_write(32'h7FF0, 32'h2);
    set_rd(32'h7FF0);
    n_tests++; if (pr_rd !== 32'h2) begin n_fail++; $display("FAIL edge_set_wins: got %h want 2", pr_rd); end
    tick();
    n_tests++; if (hw_int !== 6'h02) begin n_fail++; $display("FAIL edge_set_wins_hw: got %h want 02", hw_int); end
    bus_write(32'h7FF8, 32'h0);
    bus_write(32'h7FF4, 32'h0);
    tick();
  endtask

  task automatic test_mask_raw();
    dev_irq = 4'b0011;
    bus_write(32'h7FF4, 32'h3);
    tick(); tick(); tick();
    n_tests++; if (hw_int !== 6'h03) begin n_fail++; $display("FAIL mask_both: got %h want 03", hw_int); end
    bus_write(32'h7FF4, 32'h1);
    n_tests++; if (hw_int !== 6'h03) begin n_fail++; $display("FAIL mask_one_edge: got %h want 03", hw_int); end
    tick();
    n_tests++; if (hw_int !== 6'h01) begin n_fail++; $display("FAIL mask_two_edges: got %h want 01", hw_int); end
    set_rd(32'h7FFC);
    n_tests++; if (pr_rd !== 32'h3) begin n_fail++; $display("FAIL raw_now: got %h want 3", pr_rd); end
    dev_irq = 4'b0110; #1;
    n_tests++; if (pr_rd !== 32'h3) begin n_fail++; $display("FAIL raw_before_edge: got %h want 3", pr_rd); end
    tick();
    n_tests++; if (pr_rd !== 32'h6) begin n_fail++; $display("FAIL raw_after_edge: got %h want 6", pr_rd); end
  endtask

  task automatic test_async_reset();
    dev_irq = 4'b0011;
    bus_write(32'h7FF4, 32'h3);
    tick(); tick(); tick();
    n_tests++; if (hw_int !== 6'h03) begin n_fail++; $display("FAIL areset_pre: got %h want 03", hw_int); end
    #3; rst = 1'b0; #1;
    model_reset();
    n_tests++; if (hw_int !== 6'h00) begin n_fail++; $display("FAIL areset_hw_int: got %h want 00", hw_int); end
    set_rd(32'h7FF4);
    n_tests++; if (pr_rd !== 32'h0) begin n_fail++; $display("FAIL areset_mask: got %h want 0", pr_rd); end
    set_rd(32'h7FF0);
    n_tests++; if (pr_rd !== 32'h0) begin n_fail++; $display("FAIL areset_pending: got %h want 0", pr_rd); end
    rst = 1'b1;
    tick(); tick(); tick(); tick();
    n_tests++; if (hw_int !== 6'h00) begin n_fail++; $display("FAIL areset_masked: got %h want 00", hw_int); end
    bus_write(32'h7FF4, 32'h3);
    tick();
    n_tests++; if (hw_int !== 6'h03) begin n_fail++; $display("FAIL areset_remask: got %h want 03", hw_int); end
  endtask

  task automatic test_random();
    for (int i = 0; i < int'(NDEV); i++) dev_out[32*i +: 32] = $urandom;
    for (int n = 0; n < 400; n++) begin
      dev_irq = NDEV'($urandom);
      pr_wd   = $urandom;
      pr_we   = 1'b0;
      case ($urandom_range(0, 5))
        0: begin pr_addr = BASE | 32'hF0 | ($urandom_range(0, 3) << 2); pr_we = 1'b1; end
        1: begin pr_addr = BASE | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15); pr_we = 1'b1; end
        2: begin pr_addr = $urandom; pr_we = 1'b1; end
        default: pr_addr = BASE | $urandom_range(0, 255);
      endcase
      #1;
      n_tests++; if (dev_we !== exp_we()) begin n_fail++; $display("FAIL rand_we[%0d]: got %b want %b", n, dev_we, exp_we()); end
      n_tests++; if (pr_rd !== exp_rd(pr_addr)) begin n_fail++; $display("FAIL rand_rd[%0d]: addr %h got %h want %h", n, pr_addr, pr_rd, exp_rd(pr_addr)); end
      n_tests++; if (hw_int !== m_hw) begin n_fail++; $display("FAIL rand_hw_int[%0d]: got %h want %h", n, hw_int, m_hw); end
      n_tests++; if (dev_addr !== {4'b0, pr_addr[3:0]}) begin n_fail++; $display("FAIL rand_dev_addr[%0d]: got %h", n, dev_addr); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_read_mux();
    test_level();
    test_edge();
    test_mask_raw();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
